// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg
//   Shared definitions for the hex display blocks:
//   - mode_e      : display mode encodings (2'b11 behaves like manual)
//   - SEG_BLANK   : active-low "all segments off" pattern
//   - SEG_TABLE   : active-low 7-segment font for 0-F, bit0 = a ... bit6 = g
package hex_disp_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL     = 2'b00,
    MODE_AUTO       = 2'b01,
    MODE_FREEZE     = 2'b10,
    MODE_MANUAL_ALT = 2'b11
  } mode_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

endpackage

// File: rtl/hex_seg_decode.sv
// hex_seg_decode
//   Purely combinational nibble to 7-segment decoder (active-low segments).
// Ports:
//   nibble : 4-bit hex value
//   seg    : segment pattern, bit0 = a ... bit6 = g, 0 = segment lit
module hex_seg_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/hex_scan_display.sv
// hex_scan_display
//   Time-multiplexed hex display controller. Selects one of NUM_CH debug
//   words (manually or by auto-rotation), snapshots it once per frame and
//   scans it digit by digit onto a shared segment bus.
// Ports:
//   clk        : system clock
//   reset      : asynchronous reset, active low
//   ch_data    : packed channels, channel k = [k*CH_WIDTH +: CH_WIDTH]
//   ch_sel     : manual channel select (values >= NUM_CH clamp to last)
//   mode       : 00 manual, 01 auto-rotate, 10 freeze, 11 manual
//   blank_lz   : leading-zero blanking enable
//   blink      : blink enable
//   seg        : segment bus, active low
//   dig_an     : digit enables, active low, at most one bit low
//   cur_ch     : channel currently held in the snapshot
//   frame_tick : one-cycle pulse after the scan wraps to digit 0
module hex_scan_display
  import hex_disp_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CH_WIDTH     = 16,
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int ROT_FRAMES   = 256,
  parameter int BLINK_FRAMES = 64,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH*CH_WIDTH-1:0] ch_data,
  input  logic [CH_W-1:0]            ch_sel,
  input  logic [1:0]                 mode,
  input  logic                       blank_lz,
  input  logic                       blink,
  output logic [6:0]                 seg,
  output logic [NUM_DIGITS-1:0]      dig_an,
  output logic [CH_W-1:0]            cur_ch,
  output logic                       frame_tick
);

  localparam int NIB   = CH_WIDTH / 4;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int ROT_W = (ROT_FRAMES > 1) ? $clog2(ROT_FRAMES) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);
  localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT_FRAMES - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

  mode_e mode_q;
  assign mode_q = mode_e'(mode);

  logic [PRE_W-1:0]      presc_reg;
  logic [DIG_W-1:0]      dig_reg;
  logic                  frame_tick_reg;
  logic [CH_WIDTH-1:0]   snap_reg, snap_next;
  logic [CH_W-1:0]       cur_reg, cur_next;
  logic [ROT_W-1:0]      rot_reg, rot_next;
  logic [BLK_W-1:0]      blk_reg, blk_next;
  logic                  phase_reg, phase_next;
  logic [6:0]            seg_reg, seg_next;
  logic [NUM_DIGITS-1:0] an_reg, an_next;

  logic step, wrap;
  assign step = (presc_reg == PRE_LAST);
  assign wrap = step && (dig_reg == DIG_LAST);

  // Unpack channels and snapshot nibbles.
  logic [CH_WIDTH-1:0] ch_words [NUM_CH];
  logic [3:0]          nibbles  [NIB];
  logic [NIB-1:0]      upper_zero;   // nibble gi and all above it are zero

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_words[gi] = ch_data[gi*CH_WIDTH +: CH_WIDTH];
  end

  for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
    assign nibbles[gi]    = snap_reg[4*gi +: 4];
    assign upper_zero[gi] = ~|snap_reg[CH_WIDTH-1:4*gi];
  end

  // Channel that the snapshot would load at this wrap.
  logic [CH_W-1:0] sel_clamped, next_ch, load_idx;
  logic            do_load;
  logic [CH_WIDTH-1:0] load_word;

  assign sel_clamped = (int'(ch_sel) >= NUM_CH) ? CH_LAST : ch_sel;
  assign next_ch     = (cur_reg == CH_LAST) ? '0 : cur_reg + CH_W'(1);

  always_comb begin
    load_idx = cur_reg;
    do_load  = 1'b0;
    if (wrap) begin
      case (mode_q)
        MODE_FREEZE: do_load = 1'b0;
        MODE_AUTO: begin
          do_load  = 1'b1;
          load_idx = (rot_reg == ROT_LAST) ? next_ch : cur_reg;
        end
        default: begin
          do_load  = 1'b1;
          load_idx = sel_clamped;
        end
      endcase
    end
  end

  always_comb begin
    load_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (load_idx == CH_W'(k)) load_word = ch_words[k];
    end
  end

  // Frame-rate state: snapshot, channel, rotation and blink counters.
  always_comb begin
    snap_next  = snap_reg;
    cur_next   = cur_reg;
    rot_next   = rot_reg;
    blk_next   = blk_reg;
    phase_next = phase_reg;
    // Outside auto mode the rotation counter is held clear, so entering
    // auto always gives the current channel a full ROT_FRAMES frames.
    if (mode_q != MODE_AUTO) begin
      rot_next = '0;
    end else if (wrap) begin
      rot_next = (rot_reg == ROT_LAST) ? '0 : rot_reg + ROT_W'(1);
    end
    if (do_load) begin
      snap_next = load_word;
      cur_next  = load_idx;
    end
    if (wrap) begin
      if (blk_reg == BLK_LAST) begin
        blk_next   = '0;
        phase_next = ~phase_reg;
      end else begin
        blk_next = blk_reg + BLK_W'(1);
      end
    end
  end

  // Digit content for the currently indexed digit.
  logic [3:0] cur_nib;
  logic       lit;
  logic [6:0] seg_dec;

  always_comb begin
    cur_nib = 4'h0;
    lit     = 1'b0;
    for (int i = 0; i < NIB; i++) begin
      if (dig_reg == DIG_W'(i)) begin
        cur_nib = nibbles[i];
        lit     = !(blank_lz && (i != 0) && upper_zero[i]);
      end
    end
    if (blink && !phase_reg) lit = 1'b0;
  end

  hex_seg_decode u_dec (
    .nibble (cur_nib),
    .seg    (seg_dec)
  );

  always_comb begin
    seg_next = SEG_BLANK;
    an_next  = '1;
    if (lit) begin
      seg_next = seg_dec;
      an_next  = ~(NUM_DIGITS'(1) << dig_reg);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_reg      <= '0;
      dig_reg        <= '0;
      frame_tick_reg <= 1'b0;
      snap_reg       <= '0;
      cur_reg        <= '0;
      rot_reg        <= '0;
      blk_reg        <= '0;
      phase_reg      <= 1'b1;
      seg_reg        <= SEG_BLANK;
      an_reg         <= '1;
    end else begin
      presc_reg      <= step ? '0 : presc_reg + PRE_W'(1);
      if (step) dig_reg <= wrap ? '0 : dig_reg + DIG_W'(1);
      frame_tick_reg <= wrap;
      snap_reg       <= snap_next;
      cur_reg        <= cur_next;
      rot_reg        <= rot_next;
      blk_reg        <= blk_next;
      phase_reg      <= phase_next;
      seg_reg        <= seg_next;
      an_reg         <= an_next;
    end
  end

  assign seg        = seg_reg;
  assign dig_an     = an_reg;
  assign cur_ch     = cur_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_hex_scan_display.sv
module tb_hex_scan_display;

  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int ND  = 6;
  localparam int SD  = 2;
  localparam int RF  = 2;
  localparam int BF  = 1;
  localparam int FR  = SD * ND;   // clocks per frame

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NCH*CW-1:0] ch_data;
  logic [1:0]        ch_sel;
  logic [1:0]        mode;
  logic              blank_lz;
  logic              blink;
  logic [6:0]        seg;
  logic [ND-1:0]     dig_an;
  logic [1:0]        cur_ch;
  logic              frame_tick;

  hex_scan_display #(
    .NUM_CH       (NCH),
    .CH_WIDTH     (CW),
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .ROT_FRAMES   (RF),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ch_data    (ch_data),
    .ch_sel     (ch_sel),
    .mode       (mode),
    .blank_lz   (blank_lz),
    .blink      (blink),
    .seg        (seg),
    .dig_an     (dig_an),
    .cur_ch     (cur_ch),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: everything derived from the clock count since reset.
  int          e;        // posedge index since reset release
  logic [CW-1:0] m_snap;
  int          m_cur;
  int          m_rot;    // frames spent on current channel in auto mode
  int          m_bcnt;
  bit          m_on;     // blink phase
  logic [6:0]  seg_log [0:23];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] font(input logic [3:0] v);
    case (v)
      4'h0: font = 7'h40;  4'h1: font = 7'h79;  4'h2: font = 7'h24;  4'h3: font = 7'h30;
      4'h4: font = 7'h19;  4'h5: font = 7'h12;  4'h6: font = 7'h02;  4'h7: font = 7'h78;
      4'h8: font = 7'h00;  4'h9: font = 7'h10;  4'hA: font = 7'h08;  4'hB: font = 7'h03;
      4'hC: font = 7'h46;  4'hD: font = 7'h21;  4'hE: font = 7'h06;  default: font = 7'h0E;
    endcase
  endfunction

  function automatic logic [CW-1:0] word(input int k);
    logic [NCH*CW-1:0] all;
    all = ch_data;
    return all[k*CW +: CW];
  endfunction

  task automatic model_reset();
    e = 0; m_snap = '0; m_cur = 0; m_rot = 0; m_bcnt = 0; m_on = 1'b1;
  endtask

  // One clock: predict outputs from the pre-edge model state, advance the
  // model, compare, then optionally scramble the channel data.
  task automatic cycle(input bit scramble);
    logic [6:0]    es;
    logic [ND-1:0] ea;
    bit            et, lit;
    int            d, sel;
    @(posedge clk);
    d   = (e / SD) % ND;
    lit = (d < CW / 4);
    if (lit && blank_lz && d != 0 && (m_snap >> (4 * d)) == 0) lit = 0;
    if (blink && !m_on) lit = 0;
    es = lit ? font(4'(m_snap >> (4 * d))) : 7'h7F;
    ea = lit ? ~(ND'(1) << d) : '1;
    et = (e % FR) == FR - 1;
    if (mode != 2'b01) m_rot = 0;
    if (et) begin
      if (mode == 2'b01) begin
        m_rot++;
        if (m_rot == RF) begin
          m_rot = 0;
          m_cur = (m_cur + 1) % NCH;
        end
        m_snap = word(m_cur);
      end else if (mode != 2'b10) begin
        sel    = int'(ch_sel);
        m_cur  = (sel >= NCH) ? NCH - 1 : sel;
        m_snap = word(m_cur);
      end
      m_bcnt++;
      if (m_bcnt == BF) begin
        m_bcnt = 0;
        m_on   = !m_on;
      end
    end
    #1;
    chk("seg", seg, es);
    chk("dig_an", dig_an, ea);
    chk("frame_tick", frame_tick, et);
    chk("cur_ch", cur_ch, m_cur);
    if (e < 24) seg_log[e] = seg;
    e++;
    @(negedge clk);
    if (scramble) ch_data = 48'({$urandom(), $urandom()});
  endtask

  task automatic run(input int n, input bit scramble);
    for (int i = 0; i < n; i++) cycle(scramble);
  endtask

  initial begin
    ch_data  = {16'hBEEF, 16'h5A5A, 16'h1234};
    ch_sel   = 2'd0;
    mode     = 2'b00;
    blank_lz = 1'b0;
    blink    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dig_an", dig_an, 6'h3F);
    chk("rst_cur_ch", cur_ch, 0);
    chk("rst_frame_tick", frame_tick, 0);
    reset = 1'b1;
    model_reset();

    // Second frame shows 1234: 4,3,2,1 then two blanks, 2 clocks per digit.
    run(2 * FR, 0);
    chk("scan_d0", seg_log[12], 7'h19);
    chk("scan_d0_hold", seg_log[13], 7'h19);
    chk("scan_d1", seg_log[14], 7'h30);
    chk("scan_d2", seg_log[16], 7'h24);
    chk("scan_d3", seg_log[18], 7'h79);
    chk("scan_d4", seg_log[20], 7'h7F);
    chk("scan_d5", seg_log[22], 7'h7F);
    $display("txn manual 1234 done, cycles=%0d", e);

    // Mid-frame channel change only lands on the next frame.
    run(5, 0);
    ch_sel = 2'd2;
    run(FR - 5 + FR, 0);
    chk("sel_cur_ch", cur_ch, 2);
    $display("txn ch_sel 0->2 done, cur_ch=%0d", cur_ch);

    // Leading-zero blanking.
    ch_sel = 2'd0; blank_lz = 1'b1;
    ch_data[15:0] = 16'h0050;
    run(2 * FR, 0);
    ch_data[15:0] = 16'h0000;
    run(2 * FR, 0);
    $display("txn blank_lz done");

    // Auto-rotate, then freeze with data churning, then blink.
    blank_lz = 1'b0; mode = 2'b01;
    run(8 * FR, 0);
    $display("txn auto-rotate done, cur_ch=%0d", cur_ch);
    mode = 2'b10;
    run(3 * FR, 1);
    $display("txn freeze done, cur_ch=%0d", cur_ch);
    mode = 2'b00; blink = 1'b1;
    run(4 * FR, 1);
    $display("txn blink done");

    // Random phases.
    for (int p = 0; p < 24; p++) begin
      mode     = 2'($urandom_range(0, 3));
      ch_sel   = 2'($urandom_range(0, 3));
      blank_lz = 1'($urandom_range(0, 1));
      blink    = 1'($urandom_range(0, 1));
      ch_data  = 48'({$urandom(), $urandom()}) & {3{16'h00FF | 16'($urandom())}};
      run($urandom_range(1, 4 * FR), 1'($urandom_range(0, 1)));
      $display("txn random phase %0d mode=%0d sel=%0d lz=%0b blink=%0b cur_ch=%0d",
               p, mode, ch_sel, blank_lz, blink, cur_ch);
    end

    // Asynchronous reset mid-frame, away from any clock edge.
    run(3, 0);
    #3;
    reset = 1'b0;
    #1;
    chk("async_seg", seg, 7'h7F);
    chk("async_dig_an", dig_an, 6'h3F);
    chk("async_cur_ch", cur_ch, 0);
    chk("async_frame_tick", frame_tick, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    mode = 2'b00; ch_sel = 2'd1; blink = 1'b0; blank_lz = 1'b1;
    run(3 * FR, 0);
    $display("txn post-reset done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_scan_display.md
Name: hex_scan_display

Overview:
- Parametrised, time-multiplexed hex display controller. Successor to the fixed per-digit hexTo7Seg fan-out at the CPU top level.
- Takes NUM_CH packed CPU debug words (ALU bus, r15, r8, memory port, ...) and selects one channel, manually or by auto-rotation.
- Snapshots the selected word once per frame so the display is coherent, then scans it onto a shared segment bus with one-hot digit enables.
- Adds leading-zero blanking, blink and freeze modes.

Parameters:
- NUM_CH, 4, number of input channels (>=1)
- CH_WIDTH, 16, bits per channel; must be a multiple of 4
- NUM_DIGITS, 6, physical digits; must be >= CH_WIDTH/4
- SCAN_DIV, 50000, clk cycles per digit step (>=1)
- ROT_FRAMES, 256, frames per channel in auto-rotate mode (>=1)
- BLINK_FRAMES, 64, frames per blink half-period (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ch_data  in  NUM_CH*CH_WIDTH  packed channels; channel k = bits [k*CH_WIDTH +: CH_WIDTH]
- ch_sel  in  clog2(NUM_CH) (min 1)  manual channel select
- mode  in  2  00 manual, 01 auto-rotate, 10 freeze, 11 treated as manual
- blank_lz  in  1  leading-zero blanking enable
- blink  in  1  blink enable
- seg  out  7  segment bus, active-low, bit0=a … bit6=g
- dig_an  out  NUM_DIGITS  digit enables, active-low, one-hot when lit
- cur_ch  out  clog2(NUM_CH) (min 1)  channel currently in the snapshot
- frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low.
- Reset values:
  - seg = 7'h7F, dig_an = all ones (nothing lit).
  - cur_ch = 0, frame_tick = 0.
  - All counters 0, snapshot 0, blink phase = on.
- Prescaler:
  - Counts 0..SCAN_DIV-1.
  - step = 1 in the cycle where count == SCAN_DIV-1; the counter then wraps to 0.
  - With SCAN_DIV = 1, step = 1 every cycle.
- Digit index d:
  - Advances by 1 on each step and wraps NUM_DIGITS-1 -> 0.
  - frame_tick is registered and pulses the cycle after the step that wraps d to 0.
- Snapshot update: happens on the same step as the wrap to 0, and is skipped when mode = 10.
  - Manual mode: snapshot <= channel ch_sel and cur_ch <= ch_sel.
  - ch_sel >= NUM_CH is clamped to NUM_CH-1.
- Auto-rotate mode:
  - A frame counter increments each frame.
  - When it reaches ROT_FRAMES-1, it clears and cur_ch advances by 1, wrapping NUM_CH-1 -> 0. The snapshot then loads the new channel.
  - Entering auto mode starts from the current cur_ch with the frame counter cleared.
- Freeze mode:
  - Snapshot and cur_ch hold.
  - Scanning, blink and frame_tick continue.
- Digit content:
  - Digit i shows nibble i of the snapshot (digit 0 = LS nibble).
  - Digits i >= CH_WIDTH/4 are always blank.
- Leading-zero blanking (blank_lz = 1):
  - Digit i is blank if every nibble j >= i is zero, except digit 0.
  - Digit 0 is always lit, so a value of 0 shows "0".
- Blink:
  - The blink phase toggles every BLINK_FRAMES frames.
  - When blink = 1 and the phase is off, all of dig_an are high.
  - When blink = 0, the phase counter keeps running but has no effect.
- Output timing:
  - seg and dig_an are registered, one cycle after d changes.
  - Blank digit: seg = 7'h7F and its dig_an bit stays high. No ghosting: only one dig_an bit is ever low.
- Inputs sampled at a step boundary apply from the next frame. ch_data changes mid-frame never reach the display until the next snapshot.
- Reset asserted mid-frame returns everything to the reset values immediately, without waiting for a clock.

Decomposition:
- Shared package (hex_disp_pkg):
  - Mode encodings MODE_MANUAL, MODE_AUTO, MODE_FREEZE.
  - Constant SEG_BLANK = 7'h7F.
  - 16-entry active-low segment table for 0-F.
- One sub-module: hex_seg_decode. Purely combinational nibble -> 7-bit active-low pattern, shared with future display blocks.

Test Plan:
- Reset release, SCAN_DIV=2, NUM_DIGITS=6, ch0=16'h1234, manual ch_sel=0:
  - Digits 0..3 scan 4,3,2,1 with seg = 7'h19, 7'h30, 7'h24, 7'h79.
  - Digits 4-5 are blank.
  - Each digit is held for 2 clk.
- blank_lz=1 with ch0=16'h0050 -> digits 0,1 show 0,5; digits 2-5 blank. With ch0=0 -> only digit 0 lit, seg = 7'h40.
- ch_sel changed 0->2 mid-frame (ch2=16'hBEEF) -> display unchanged until frame_tick; next frame shows F,E,E,B and cur_ch = 2.
- mode=01, ROT_FRAMES=2, NUM_CH=3 -> cur_ch sequence 0,1,2,0 changing every 2 frames.
- mode=10 while ch data toggles every cycle -> seg pattern identical across 3 frames; frame_tick still pulses each frame.
- blink=1, BLINK_FRAMES=1 -> dig_an all high on alternate frames. Asserting reset low mid-frame -> seg = 7'h7F and dig_an = all ones within the same cycle, with no clock edge needed.
